brownout_ctrl: RTL and testbench

- Register-programmed supervisor that drives the brownout detector's configuration inputs: enable, trip codes and force bits.
- Consumes the detector's brownout and timed-out outputs, which arrive asynchronously on the system clock.
- Sequences enable and re-trim with a settle-blanking window, then classifies detector state.
- Counts brownout events, keeps sticky status and raises an interrupt; sits between the system register bus and the analog brownout macro.

---
 rtl/brownout_ctrl_if.sv | 22 ++
 rtl/brownout_ctrl.sv | 150 +++++++++++++++
 tb/tb_brownout_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/brownout_ctrl_if.sv
// Register-bus bundle between the system register master and the brownout supervisor.
// Single-cycle write strobe; read data is a combinational decode of the address.
interface brownout_ctrl_if;
    logic       reg_wr;
    logic [1:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;

    modport master (
        output reg_wr,
        output reg_addr,
        output reg_wdata,
        input  reg_rdata
    );

    modport slave (
        input  reg_wr,
        input  reg_addr,
        input  reg_wdata,
        output reg_rdata
    );
endinterface

// File: rtl/brownout_ctrl.sv
// Brownout detector supervisor: register-programmed enable/trim, settle blanking, event count, sticky irq.
// Detector outputs update one cycle after a write; async detector inputs reach the FSM after SYNC_STAGES flops.
module brownout_ctrl #(
    parameter int SETTLE_CYC  = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 sys_ck,
    input  logic                 rst,
    brownout_ctrl_if.slave       bus,
    input  logic                 bo_out_async,
    input  logic                 bo_timed_out_async,
    output logic                 bo_ena,
    output logic [2:0]           bo_vtrip,
    output logic [2:0]           bo_otrip,
    output logic                 bo_force_rc_osc,
    output logic                 bo_force_short_oneshot,
    output logic                 bo_ready,
    output logic                 irq
);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ARMED  = 2'd2,
        ST_BROWN  = 2'd3
    } state_t;

    localparam logic [15:0] LP_RELOAD = 16'(SETTLE_CYC - 1);

    state_t                 r_state;
    logic [15:0]            r_cnt;
    logic [3:0]             r_ctrl;
    logic [2:0]             r_vtrip;
    logic [2:0]             r_otrip;
    logic                   r_sticky;
    logic [7:0]             r_evcnt;
    logic                   r_irq;
    logic                   r_bo_ena;
    logic [SYNC_STAGES-1:0] r_sync_bo;
    logic [SYNC_STAGES-1:0] r_sync_to;

    state_t      w_state_nxt;
    logic [15:0] w_cnt_nxt;
    logic        w_event;
    logic        w_bo_sync;
    logic        w_to_sync;
    logic        w_wr_ctrl;
    logic        w_wr_trip;
    logic        w_wr_stat;
    logic        w_wr_evcnt;
    logic        w_en;
    logic        w_unused;

    assign w_wr_ctrl  = bus.reg_wr && (bus.reg_addr == 2'd0);
    assign w_wr_trip  = bus.reg_wr && (bus.reg_addr == 2'd1);
    assign w_wr_stat  = bus.reg_wr && (bus.reg_addr == 2'd2);
    assign w_wr_evcnt = bus.reg_wr && (bus.reg_addr == 2'd3);
    assign w_bo_sync  = r_sync_bo[SYNC_STAGES-1];
    assign w_to_sync  = r_sync_to[SYNC_STAGES-1];
    assign w_unused   = bus.reg_wdata[7];

    // A CTRL write takes effect on the FSM in the same edge it lands in the register.
    assign w_en = w_wr_ctrl ? bus.reg_wdata[0] : r_ctrl[0];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_event     = 1'b0;
        if (!w_en) begin
            w_state_nxt = ST_OFF;
        end else if (w_wr_trip && (r_state != ST_OFF)) begin
            w_state_nxt = ST_SETTLE;
            w_cnt_nxt   = LP_RELOAD;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = LP_RELOAD;
                end
                ST_SETTLE: begin
                    if (r_cnt == 16'd0) w_state_nxt = ST_ARMED;
                    else                w_cnt_nxt   = r_cnt - 16'd1;
                end
                ST_ARMED: begin
                    if (w_bo_sync) begin
                        w_state_nxt = ST_BROWN;
                        w_event     = 1'b1;
                    end
                end
                ST_BROWN: begin
                    if (!w_bo_sync) w_state_nxt = ST_ARMED;
                end
                default: w_state_nxt = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge sys_ck) begin
        if (rst) begin
            r_state   <= ST_OFF;
            r_cnt     <= '0;
            r_ctrl    <= '0;
            r_vtrip   <= '0;
            r_otrip   <= '0;
            r_sticky  <= 1'b0;
            r_evcnt   <= '0;
            r_irq     <= 1'b0;
            r_bo_ena  <= 1'b0;
            r_sync_bo <= '0;
            r_sync_to <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bo_ena  <= (w_state_nxt != ST_OFF);
            r_irq     <= r_sticky & r_ctrl[3];
            r_sync_bo <= {r_sync_bo[SYNC_STAGES-2:0], bo_out_async};
            r_sync_to <= {r_sync_to[SYNC_STAGES-2:0], bo_timed_out_async};
            if (w_wr_ctrl) r_ctrl <= bus.reg_wdata[3:0];
            if (w_wr_trip) begin
                r_vtrip <= bus.reg_wdata[2:0];
                r_otrip <= bus.reg_wdata[6:4];
            end
            // A new event wins over a same-cycle clear on both sticky and count.
            if (w_event)                         r_sticky <= 1'b1;
            else if (w_wr_stat && bus.reg_wdata[1]) r_sticky <= 1'b0;
            if (w_wr_evcnt)                      r_evcnt <= {7'd0, w_event};
            else if (w_event && (r_evcnt != 8'hFF)) r_evcnt <= r_evcnt + 8'd1;
        end
    end

    always_comb begin
        bus.reg_rdata = 8'h00;
        case (bus.reg_addr)
            2'd0: bus.reg_rdata = {4'b0000, r_ctrl};
            2'd1: bus.reg_rdata = {1'b0, r_otrip, 1'b0, r_vtrip};
            2'd2: bus.reg_rdata = {2'b00, r_state, w_to_sync, bo_ready, r_sticky, w_bo_sync};
            2'd3: bus.reg_rdata = r_evcnt;
            default: bus.reg_rdata = 8'h00;
        endcase
    end

    assign bo_ena                 = r_bo_ena;
    assign bo_vtrip               = r_vtrip;
    assign bo_otrip               = r_otrip;
    assign bo_force_rc_osc        = r_ctrl[1];
    assign bo_force_short_oneshot = r_ctrl[2];
    assign bo_ready               = (r_state == ST_ARMED) || (r_state == ST_BROWN);
    assign irq                    = r_irq;

endmodule

// File: tb/tb_brownout_ctrl.sv
// Bench for brownout_ctrl: directed steps plus random traffic against a cycle-level reference of the register/FSM rules.
module tb_brownout_ctrl;
    localparam int SETTLE = 64;
    localparam int SYNC   = 2;

    logic       sys_ck = 1'b0;
    logic       rst;
    logic       bo_in, to_in;
    logic       bo_ena, bo_ready, irq, f_rc, f_so;
    logic [2:0] bo_vtrip, bo_otrip;

    always #5 sys_ck = ~sys_ck;

    brownout_ctrl_if bus();

    brownout_ctrl #(.SETTLE_CYC(SETTLE), .SYNC_STAGES(SYNC)) dut (
        .sys_ck                 (sys_ck),
        .rst                    (rst),
        .bus                    (bus),
        .bo_out_async           (bo_in),
        .bo_timed_out_async     (to_in),
        .bo_ena                 (bo_ena),
        .bo_vtrip               (bo_vtrip),
        .bo_otrip               (bo_otrip),
        .bo_force_rc_osc        (f_rc),
        .bo_force_short_oneshot (f_so),
        .bo_ready               (bo_ready),
        .irq                    (irq)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference: mode 0=off 1=settling 2=armed 3=brownout, m_left = blanking cycles remaining after this one.
    int       m_mode, m_left, m_cnt;
    bit [3:0] m_ctrl;
    bit [2:0] m_vt, m_ot;
    bit       m_sticky, m_irq, m_ena;
    bit       m_pbo[SYNC];
    bit       m_pto[SYNC];

    function automatic logic [7:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {4'b0000, m_ctrl};
            2'd1:    return {1'b0, m_ot, 1'b0, m_vt};
            2'd2:    return {2'b00, 2'(m_mode), m_pto[SYNC-1], (m_mode >= 2), m_sticky, m_pbo[SYNC-1]};
            default: return 8'(m_cnt);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit sync_bo, irq_n, ev, wr_c, wr_t, wr_s, wr_e;
        logic [7:0] d;
        if (rst) begin
            m_mode = 0; m_left = 0; m_cnt = 0; m_ctrl = 0; m_vt = 0; m_ot = 0;
            m_sticky = 0; m_irq = 0; m_ena = 0;
            for (int i = 0; i < SYNC; i++) begin m_pbo[i] = 0; m_pto[i] = 0; end
            return;
        end
        d       = bus.reg_wdata;
        sync_bo = m_pbo[SYNC-1];
        irq_n   = m_sticky && m_ctrl[3];
        wr_c    = bus.reg_wr && bus.reg_addr == 2'd0;
        wr_t    = bus.reg_wr && bus.reg_addr == 2'd1;
        wr_s    = bus.reg_wr && bus.reg_addr == 2'd2;
        wr_e    = bus.reg_wr && bus.reg_addr == 2'd3;
        for (int i = SYNC - 1; i > 0; i--) begin m_pbo[i] = m_pbo[i-1]; m_pto[i] = m_pto[i-1]; end
        m_pbo[0] = bo_in;
        m_pto[0] = to_in;
        if (wr_c) m_ctrl = d[3:0];
        if (wr_t) begin m_vt = d[2:0]; m_ot = d[6:4]; end
        ev = 0;
        if (!m_ctrl[0])                    m_mode = 0;
        else if (wr_t && m_mode != 0)      begin m_mode = 1; m_left = SETTLE - 1; end
        else if (m_mode == 0)              begin m_mode = 1; m_left = SETTLE - 1; end
        else if (m_mode == 1)              begin if (m_left == 0) m_mode = 2; else m_left--; end
        else if (m_mode == 2)              begin if (sync_bo) begin m_mode = 3; ev = 1; end end
        else if (!sync_bo)                 m_mode = 2;
        if (wr_e)    m_cnt = ev ? 1 : 0;
        else if (ev) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        if (ev)                m_sticky = 1;
        else if (wr_s && d[1]) m_sticky = 0;
        m_irq = irq_n;
        m_ena = (m_mode != 0);
    endtask

    task automatic tick(input logic wr, input logic [1:0] a, input logic [7:0] d);
        logic [31:0] obs, exp;
        bus.reg_wr    = wr;
        bus.reg_addr  = a;
        bus.reg_wdata = d;
        @(posedge sys_ck);
        model_edge();
        #1;
        obs = {13'd0, bo_ena, bo_vtrip, bo_otrip, f_rc, f_so, bo_ready, irq, bus.reg_rdata};
        exp = {13'd0, m_ena, m_vt, m_ot, m_ctrl[1], m_ctrl[2], (m_mode >= 2), m_irq, m_read(a)};
        check("cycle", obs, exp);
    endtask

    initial begin
        rst = 1'b1; bo_in = 1'b0; to_in = 1'b0;
        bus.reg_wr = 1'b0; bus.reg_addr = 2'd0; bus.reg_wdata = 8'h00;
        repeat (3) tick(0, 2'd0, 8'h00);
        rst = 1'b0;
        for (int a = 0; a < 4; a++) begin
            tick(0, 2'(a), 8'h00);
            check("reset_read", bus.reg_rdata, 8'h00);
        end
        check("reset_outs", {bo_ena, bo_vtrip, bo_otrip, f_rc, f_so, bo_ready, irq}, 11'd0);

        // Enable and settle blanking length.
        tick(1, 2'd0, 8'h01);
        check("ena_next", bo_ena, 1'b1);
        repeat (63) tick(0, 2'd2, 8'h00);
        check("settle_last", bus.reg_rdata[5:4], 2'd1);
        tick(0, 2'd2, 8'h00);
        check("armed", bus.reg_rdata[5:4], 2'd2);
        check("ready", bo_ready, 1'b1);

        // Single brownout pulse with irq enabled.
        tick(1, 2'd0, 8'h09);
        bo_in = 1'b1;
        repeat (2) tick(0, 2'd2, 8'h00);
        check("pre_brown", bus.reg_rdata[5:4], 2'd2);
        tick(0, 2'd2, 8'h00);
        check("brown_lat", bus.reg_rdata[5:4], 2'd3);
        check("sticky", bus.reg_rdata[1], 1'b1);
        tick(0, 2'd3, 8'h00);
        check("irq_lat", irq, 1'b1);
        check("evcnt1", bus.reg_rdata, 8'd1);
        repeat (6) tick(0, 2'd2, 8'h00);
        bo_in = 1'b0;
        repeat (3) tick(0, 2'd2, 8'h00);
        check("rearm", bus.reg_rdata[5:4], 2'd2);
        tick(1, 2'd2, 8'h02);
        tick(0, 2'd2, 8'h00);
        check("irq_clr", irq, 1'b0);

        // Brownout held through blanking, then re-trim from brownout.
        tick(1, 2'd3, 8'h00);
        tick(1, 2'd0, 8'h08);
        bo_in = 1'b1;
        repeat (3) tick(0, 2'd3, 8'h00);
        tick(1, 2'd0, 8'h09);
        repeat (64) tick(0, 2'd3, 8'h00);
        check("blank_nocount", bus.reg_rdata, 8'd0);
        tick(0, 2'd3, 8'h00);
        check("post_blank_cnt", bus.reg_rdata, 8'd1);
        tick(1, 2'd1, 8'h53);
        check("vtrip", bo_vtrip, 3'd3);
        check("otrip", bo_otrip, 3'd5);
        tick(0, 2'd2, 8'h00);
        check("retrim_settle", bus.reg_rdata[5:4], 2'd1);
        tick(0, 2'd3, 8'h00);
        check("retrim_keep", bus.reg_rdata, 8'd1);

        // Saturation and same-cycle clear/event.
        bo_in = 1'b0;
        repeat (70) tick(0, 2'd3, 8'h00);
        for (int p = 0; p < 300; p++) begin
            bo_in = 1'b1; repeat (2) tick(0, 2'd3, 8'h00);
            bo_in = 1'b0; repeat (3) tick(0, 2'd3, 8'h00);
        end
        check("saturate", bus.reg_rdata, 8'd255);
        bo_in = 1'b1;
        repeat (2) tick(0, 2'd3, 8'h00);
        tick(1, 2'd3, 8'h00);
        check("clr_vs_event", bus.reg_rdata, 8'd1);
        bo_in = 1'b0;
        repeat (3) tick(0, 2'd2, 8'h00);
        bo_in = 1'b1;
        repeat (2) tick(0, 2'd2, 8'h00);
        tick(1, 2'd2, 8'h02);
        check("w1c_vs_event", bus.reg_rdata[1], 1'b1);

        // Disable from brownout, then reset mid-settle.
        tick(1, 2'd0, 8'h00);
        check("dis_ena", bo_ena, 1'b0);
        tick(0, 2'd2, 8'h00);
        check("dis_off", bus.reg_rdata[5:4], 2'd0);
        tick(1, 2'd0, 8'h07);
        repeat (10) tick(0, 2'd2, 8'h00);
        rst = 1'b1;
        tick(0, 2'd2, 8'h00);
        rst = 1'b0;
        check("rst_status", bus.reg_rdata, 8'h00);
        check("rst_outs", {bo_ena, bo_vtrip, bo_otrip, f_rc, f_so, bo_ready, irq}, 11'd0);

        // Random traffic against the reference.
        for (int n = 0; n < 4000; n++) begin
            logic       w;
            logic [1:0] a;
            logic [7:0] d;
            if ($urandom_range(7) == 0) bo_in = ~bo_in;
            if ($urandom_range(15) == 0) to_in = ~to_in;
            rst = ($urandom_range(999) == 0);
            w = ($urandom_range(11) == 0);
            a = 2'($urandom_range(3));
            d = 8'($urandom);
            if (a == 2'd0) d[0] = ($urandom_range(15) != 0);
            tick(w, a, d);
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
